data_trans_fifo_param: RTL and testbench
========================================

// Module: data_trans_fifo_param
// PURPOSE
//   Parametrised synchronous FIFO for the data-transfer path; next generation of the fixed 8-bit byte FIFO.
//   Width/depth set by parameters; adds occupancy count, programmable almost-full/almost-empty thresholds,
//   selectable show-ahead (FWFT) or registered read, synchronous flush, and sticky overflow/underflow flags.
//   Sits between a producer issuing wr_en and a consumer issuing rd_en, both in the clk domain.
// PARAMETERS
//   DATA_W    8   data word width in bits (>=1)
//   DEPTH     16  number of entries; power of 2, >=4
//   AF_LEVEL  12  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  4   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0   0: registered read, data_o valid 1 cycle after accepted read; 1: show-ahead head word
// PORTS
//   clk           in   1            clock, all logic on rising edge
//   reset_n       in   1            asynchronous active-low reset
//   wr_en         in   1            write request
//   data_in       in   DATA_W       write data, sampled when a write is accepted
//   rd_en         in   1            read request (FWFT=1: acknowledge/pop current head)
//   flush         in   1            synchronous clear of FIFO contents
//   clr_err       in   1            synchronous clear of overflow/underflow
//   data_o        out  DATA_W       read data
//   full          out  1            count == DEPTH
//   empty         out  1            count == 0
//   almost_full   out  1            count >= AF_LEVEL
//   almost_empty  out  1            count <= AE_LEVEL
//   count         out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//   overflow      out  1            sticky: write attempted while full
//   underflow     out  1            sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (async, reset_n=0): wr/rd pointers 0, count 0, empty 1, full 0, almost_empty 1,
//     almost_full 0, data_o 0, overflow 0, underflow 0. Storage array is not reset. Reset mid-traffic
//     discards all contents; first accepted write after release lands at address 0.
//   - Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); MSB is wrap bit; address = low ADDR_W bits, wraps DEPTH-1 -> 0.
//   - Write accepted iff wr_en && !full && !flush. Read accepted iff rd_en && !empty && !flush.
//     Acceptance uses flags at the edge (pre-update state); no write-through on full even with rd_en.
//   - count: +1 on write only, -1 on read only, unchanged on both or neither. All flags registered from
//     next-state count, so they change in the same cycle count does.
//   - Write to empty FIFO: empty deasserts the cycle after the write edge.
//   - FWFT=0: data_o loads mem[rd_addr] on accepted read; holds otherwise (including on empty/flush).
//   - FWFT=1: data_o = head entry whenever !empty (visible 1 cycle after the first write to empty);
//     accepted read pops it and next entry appears next cycle; when empty data_o holds last head value.
//   - Flush: pointers and count -> 0, flags as reset; overrides wr_en/rd_en in the same cycle;
//     overflow/underflow/data_o unaffected.
//   - overflow sets on wr_en && full && !flush; underflow sets on rd_en && empty && !flush.
//     Both hold until clr_err or reset. Set and clr_err in same cycle: flag is set (set wins).
//   - Rejected requests leave pointers, count, data and storage unchanged.
// TESTING
//   1 Reset, DEPTH=16, FWFT=0: write 0x35,0xAF,0xE6 then 3 reads -> data_o 0x35,0xAF,0xE6 each 1 cycle
//     after its read; empty=1, count=0 at end.
//   2 Fill 16 words 0x00..0x0F -> almost_full at count 12, full at 16; 17th write -> overflow=1,
//     count stays 16; drain all -> order 0x00..0x0F intact across pointer wrap.
//   3 Read on empty -> underflow=1, data_o unchanged; pulse clr_err -> underflow=0; clr_err with a
//     concurrent empty read -> underflow stays 1.
//   4 Half full (8), wr_en&rd_en together 20 cycles -> count stays 8, output sequence matches input
//     order; with full, simultaneous wr/rd -> read accepted, write rejected, overflow=1, count 15.
//   5 FWFT=1: write 0xA5 to empty -> data_o=0xA5 next cycle without rd_en; rd_en pops, empty=1.
//   6 Flush with 5 entries plus wr_en -> count 0, empty 1, write dropped; reset_n low mid-burst ->
//     all outputs at reset values immediately (async), next write read back first.

Source files
------------

// File: rtl/data_trans_fifo_param_if.sv
// data_trans_fifo_param_if: producer/consumer bundle for the parametrised data-transfer FIFO
interface data_trans_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] data_o;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    modport master (
        output wr_en, data_in, rd_en, flush, clr_err,
        input  data_o, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, data_in, rd_en, flush, clr_err,
        output data_o, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/data_trans_fifo_param.sv
// data_trans_fifo_param: parametrised sync FIFO with occupancy, thresholds, flush,
// optional show-ahead read and sticky overflow/underflow flags
module data_trans_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    data_trans_fifo_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, cnt_nxt;
    logic [DATA_W-1:0] data_o, head_nxt;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;
    logic              wr_ok, rd_ok;

    always_comb begin
        wr_ok      = bus.wr_en && !full && !bus.flush;
        rd_ok      = bus.rd_en && !empty && !bus.flush;
        wr_ptr_nxt = bus.flush ? '0 : wr_ptr + CNT_W'(wr_ok);
        rd_ptr_nxt = bus.flush ? '0 : rd_ptr + CNT_W'(rd_ok);
        cnt_nxt    = bus.flush ? '0 : count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        // show-ahead: incoming word becomes the head when nothing else remains after a pop
        head_nxt   = (wr_ok && count == CNT_W'(rd_ok)) ? bus.data_in : mem[rd_ptr_nxt[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            data_o       <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= cnt_nxt;
            full         <= cnt_nxt == FULL_CNT;
            empty        <= cnt_nxt == '0;
            almost_full  <= cnt_nxt >= AF_CNT;
            almost_empty <= cnt_nxt <= AE_CNT;
            overflow     <= (bus.wr_en && full && !bus.flush) || (overflow && !bus.clr_err);
            underflow    <= (bus.rd_en && empty && !bus.flush) || (underflow && !bus.clr_err);
            if (FWFT != 0) begin
                if (cnt_nxt != '0) data_o <= head_nxt;
            end else if (rd_ok) begin
                data_o <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    assign bus.data_o       = data_o;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_data_trans_fifo_param.sv
// tb_data_trans_fifo_param: directed stimulus with queue scoreboards for registered-read
// and show-ahead instances of the FIFO
module tb_data_trans_fifo_param;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   m0, m1;
    logic a0, a1;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    data_trans_fifo_param_if #(.DATA_W(8), .DEPTH(16)) i0 ();
    data_trans_fifo_param_if #(.DATA_W(8), .DEPTH(16)) i1 ();

    data_trans_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(i0.slave)
    );
    data_trans_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(i1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
        logic wa, ra;
        i0.wr_en = w; i0.data_in = d; i0.rd_en = r; i0.flush = f; i0.clr_err = c;
        if (f) begin
            q0.delete();
            m0 = 0;
        end else begin
            wa = w && m0 < 16;
            ra = r && m0 > 0;
            if (wa) q0.push_back(d);
            m0 = m0 + int'(wa) - int'(ra);
        end
        @(posedge clk); #1;
        i0.wr_en = 0; i0.rd_en = 0; i0.flush = 0; i0.clr_err = 0;
    endtask

    task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
        logic wa, ra;
        i1.wr_en = w; i1.data_in = d; i1.rd_en = r;
        wa = w && m1 < 16;
        ra = r && m1 > 0;
        if (wa) q1.push_back(d);
        m1 = m1 + int'(wa) - int'(ra);
        @(posedge clk); #1;
        i1.wr_en = 0; i1.rd_en = 0;
    endtask

    // registered-read monitor: word is due one edge after an accepted read
    initial forever begin
        @(posedge clk);
        a0 = i0.rd_en && !i0.empty && !i0.flush && reset_n;
        #1;
        if (a0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd0_unexpected got 0x%0h expected no read data", i0.data_o);
            end else chk("rd0_data", i0.data_o, q0.pop_front());
        end
    end

    // show-ahead monitor: head must be visible whenever not empty
    initial forever begin
        @(posedge clk);
        a1 = i1.rd_en && !i1.empty && !i1.flush && reset_n;
        #1;
        if (a1 && q1.size() > 0) void'(q1.pop_front());
        if (!i1.empty) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL head1_unexpected got 0x%0h expected empty", i1.data_o);
            end else chk("head1_data", i1.data_o, q1[0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; m0 = 0; m1 = 0;
        reset_n = 0;
        i0.wr_en = 0; i0.data_in = 0; i0.rd_en = 0; i0.flush = 0; i0.clr_err = 0;
        i1.wr_en = 0; i1.data_in = 0; i1.rd_en = 0; i1.flush = 0; i1.clr_err = 0;
        #12;
        chk("rst_count", i0.count, 0);
        chk("rst_empty", i0.empty, 1);
        chk("rst_full", i0.full, 0);
        chk("rst_ae", i0.almost_empty, 1);
        chk("rst_af", i0.almost_full, 0);
        chk("rst_data", i0.data_o, 0);
        chk("rst_ovf", i0.overflow, 0);
        chk("rst_udf", i0.underflow, 0);
        #5 reset_n = 1;

        cyc(1, 8'h35, 0, 0, 0);
        chk("t1_empty_after_wr", i0.empty, 0);
        cyc(1, 8'hAF, 0, 0, 0);
        cyc(1, 8'hE6, 0, 0, 0);
        chk("t1_count3", i0.count, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        chk("t1_last", i0.data_o, 8'hE6);
        chk("t1_empty", i0.empty, 1);
        chk("t1_count0", i0.count, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            if (i == 10) chk("t2_af_11", i0.almost_full, 0);
            if (i == 11) chk("t2_af_12", i0.almost_full, 1);
            if (i == 14) chk("t2_full_15", i0.full, 0);
        end
        chk("t2_full_16", i0.full, 1);
        chk("t2_ae_16", i0.almost_empty, 0);
        cyc(1, 8'hFF, 0, 0, 0);
        chk("t2_ovf", i0.overflow, 1);
        chk("t2_count16", i0.count, 16);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
        chk("t2_drained", i0.empty, 1);

        cyc(0, 0, 0, 0, 1);
        chk("t3_ovf_clr", i0.overflow, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t3_udf", i0.underflow, 1);
        chk("t3_data_hold", i0.data_o, 8'h0F);
        cyc(0, 0, 0, 0, 1);
        chk("t3_udf_clr", i0.underflow, 0);
        cyc(0, 0, 1, 0, 1);
        chk("t3_udf_set_wins", i0.underflow, 1);
        cyc(0, 0, 0, 0, 1);

        for (int i = 0; i < 8; i++) cyc(1, 8'h40 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'h48 + 8'(i), 1, 0, 0);
        chk("t4_count8", i0.count, 8);
        chk("t4_af8", i0.almost_full, 0);
        chk("t4_ae8", i0.almost_empty, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0);
        chk("t4_full", i0.full, 1);
        cyc(1, 8'hEE, 1, 0, 0);
        chk("t4_count15", i0.count, 15);
        chk("t4_ovf", i0.overflow, 1);
        chk("t4_not_full", i0.full, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0);
        chk("t4_drained", i0.empty, 1);

        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'h80 + 8'(i), 0, 0, 0);
        chk("t6_count5", i0.count, 5);
        cyc(1, 8'h99, 0, 1, 0);
        chk("t6_flush_count", i0.count, 0);
        chk("t6_flush_empty", i0.empty, 1);
        chk("t6_flush_data", i0.data_o, 8'h67);
        cyc(0, 0, 1, 0, 0);
        chk("t6_flush_dropped_wr", i0.underflow, 1);
        cyc(1, 8'h10, 0, 0, 1);
        cyc(1, 8'h11, 0, 0, 0);
        i0.wr_en = 1; i0.data_in = 8'h12;
        #3 reset_n = 0;
        #1;
        q0.delete(); m0 = 0;
        chk("t6_rst_count", i0.count, 0);
        chk("t6_rst_empty", i0.empty, 1);
        chk("t6_rst_full", i0.full, 0);
        chk("t6_rst_ae", i0.almost_empty, 1);
        chk("t6_rst_data", i0.data_o, 0);
        chk("t6_rst_udf", i0.underflow, 0);
        i0.wr_en = 0;
        #2 reset_n = 1;
        cyc(1, 8'h77, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t6_first_after_rst", i0.data_o, 8'h77);
        chk("t6_empty_after_rst", i0.empty, 1);

        cyc1(1, 8'hA5, 0);
        chk("t5_fwft_head", i1.data_o, 8'hA5);
        chk("t5_fwft_not_empty", i1.empty, 0);
        cyc1(0, 0, 1);
        chk("t5_fwft_empty", i1.empty, 1);
        chk("t5_fwft_hold", i1.data_o, 8'hA5);
        cyc1(1, 8'hB1, 0);
        cyc1(1, 8'hC2, 0);
        chk("t5_fwft_b1", i1.data_o, 8'hB1);
        cyc1(1, 8'hD3, 1);
        chk("t5_fwft_c2", i1.data_o, 8'hC2);
        chk("t5_fwft_count2", i1.count, 2);
        cyc1(0, 0, 1);
        chk("t5_fwft_d3", i1.data_o, 8'hD3);
        cyc1(0, 0, 1);
        chk("t5_fwft_empty2", i1.empty, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
